tone_arbiter: RTL
=================

# tone_arbiter

Shares the single buzzer tone-divider datapath between two requesters: the background-music note stream and a sound-effect (SFX) source. Accepts timed note requests over valid/ready handshakes, counts each note's duration in tempo ticks, inserts an articulation gap at the end of music notes, and lets SFX pre-empt music and then resume it. Its `note_div` output drives the tone generator directly; a divider of 0 means silence.

## Interface
- `DIV_W`, 20, width of tone divider values
- `DUR_W`, 6, width of note duration in ticks
- `GAP_TICKS`, 1, silent ticks at the end of each music note

- `clk` in 1: single clock
- `rst` in 1: asynchronous, active-high reset
- `tick` in 1: one-cycle tempo pulse; all durations count in ticks
- `mus_valid` in 1: music note request valid
- `mus_ready` out 1: music request accepted when `mus_valid & mus_ready`
- `mus_div` in DIV_W: music divider; 0 = rest
- `mus_dur` in DUR_W: music duration in ticks; 0 is treated as 1
- `sfx_valid` in 1: SFX request valid
- `sfx_ready` out 1: SFX request accepted when `sfx_valid & sfx_ready`
- `sfx_div` in DIV_W: SFX divider
- `sfx_dur` in DUR_W: SFX duration in ticks; 0 is treated as 1
- `mute` in 1: forces `note_div` to 0; counting continues
- `note_div` out DIV_W: registered divider to the tone generator
- `src` out 2: current source; 00 idle, 01 music, 10 SFX
- `busy` out 1: high when state is not IDLE

## Operation
- States: IDLE, MUSIC, GAP, SFX.
- `mus_ready` = IDLE & !`sfx_valid`. `sfx_ready` = state != SFX.
- **IDLE:**
  - SFX has priority: if `sfx_valid`, accept SFX and go to SFX.
  - Otherwise, if `mus_valid`, accept music and go to MUSIC.
  - The accepting cycle loads `cnt` = max(dur, 1).
  - Music sets `gap_en` = (cnt > GAP_TICKS).
- **Countdown:** each `tick` in MUSIC, GAP or SFX decrements `cnt`.
- **MUSIC:**
  - When the decremented `cnt` equals GAP_TICKS and `gap_en` is set, go to GAP.
  - When a tick arrives with `cnt` == 1, the note is done.
- **GAP:** `note_div` = 0; exits when a tick arrives with `cnt` == 1.
- **SFX pre-emption (from MUSIC or GAP):**
  - Accept the SFX request.
  - Save `cnt`, the phase (MUSIC/GAP) and the divider into resume registers; set `resume`.
  - Go to SFX.
- **SFX end:** on a tick with `cnt` == 1:
  - If `resume` is set, restore the saved phase, count and divider, then clear `resume`.
  - Otherwise go to IDLE.
- **Note done:** go to IDLE and wait for the next request. Each note is followed by one IDLE cycle.
- **`note_div` source:** loaded on the same edge as the state change. MUSIC gives `mus_div` (latched), GAP and IDLE give 0, SFX gives `sfx_div` (latched). `mute` overrides to 0.
- **Arithmetic:** `cnt` is DUR_W wide and never decrements below 1. There is no wrap.

## Timing
- **Reset:** state IDLE, `note_div` 0, `src` 00, `busy` 0, `cnt` 0, `resume` 0. Effect is immediate on `rst` assertion, including mid-note. After reset, `mus_ready` = !`sfx_valid` and `sfx_ready` = 1.
- **Acceptance latency:** with acceptance at edge k, `note_div`, `src` and `busy` are valid after edge k.
- **Tick on the accept cycle:** ignored for the new note; counting starts at the next tick.
- **Duration example:** music with dur 4 and GAP_TICKS 1 gives tone for 3 ticks, then 0 for 1 tick, then IDLE.
- **SFX during music expiry:** if SFX is accepted on the same cycle a tick expires the music note (`cnt` == 1), the music note is complete and `resume` stays 0.
- **Ticks during SFX:** decrement only the SFX count; the saved music count is frozen.
- **`mute`:** takes effect on the next edge; releasing it restores the current source's divider on the next edge.

## Structure
- Shared package `tone_pkg`:
  - state enum
  - `src` encodings (SRC_IDLE, SRC_MUS, SRC_SFX)
  - DIV_W and DUR_W defaults
  - a `note_t` struct {div, dur}
- One sub-module, `note_timer`:
  - loadable down-counter with `tick` enable
  - `load`/`save`/`restore` ports
  - `at_gap` and `last` outputs
- The FSM and `note_div` register stay in `tone_arbiter`.

## Test plan
- **Reset:** assert `rst` mid-SFX → `note_div` = 0, `src` = 00, `busy` = 0 immediately; after release, `sfx_ready` = 1.
- **Music note with gap:** `mus_div` = 30337, `mus_dur` = 4, GAP_TICKS = 1 → `note_div` = 30337 for 3 ticks, 0 for 1 tick, then IDLE.
- **Arbitration in IDLE:** `mus_valid` and `sfx_valid` in the same cycle (`sfx_div` = 22727, dur 2) → SFX accepted, `mus_ready` = 0, `src` = 10; music accepted after SFX ends.
- **Pre-emption and resume:**
  - Music 45456, dur 6; after 2 ticks, SFX 60674, dur 2.
  - Expect SFX for 2 ticks, then 45456 resumes for the remaining 3 tone ticks, then 1 gap tick.
- **Edge cases:**
  - `mus_dur` = 0 → one tick of tone, no gap.
  - SFX accepted on the expiring tick → no resume.
  - `mute` held → `note_div` = 0 while `src`/`busy` sequence normally.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared types and encodings for the buzzer tone arbiter and its note timer.
package tone_pkg;

  localparam int DIV_W_DEF = 20;
  localparam int DUR_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUSIC = 2'd1,
    ST_GAP   = 2'd2,
    ST_SFX   = 2'd3
  } state_t;

  localparam logic [1:0] SRC_IDLE = 2'b00;
  localparam logic [1:0] SRC_MUS  = 2'b01;
  localparam logic [1:0] SRC_SFX  = 2'b10;

  typedef struct packed {
    logic [DIV_W_DEF-1:0] div;
    logic [DUR_W_DEF-1:0] dur;
  } note_t;

endpackage

// File: rtl/tone_arbiter_note_timer.sv
// Tick-driven note duration counter with a save/restore slot for pre-empted music.
module note_timer #(
  parameter int DUR_W     = 6,
  parameter int GAP_TICKS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [DUR_W-1:0] load_val,
  input  logic             save,
  input  logic             restore,
  output logic             last,
  output logic             at_gap,
  output logic             long_note
);

  logic [DUR_W-1:0] cnt_r;
  logic [DUR_W-1:0] saved_cnt_r;
  logic [DUR_W-1:0] load_clamped_s;
  logic             dec_s;

  // A zero duration plays as a single tick; the count never falls below 1.
  assign load_clamped_s = (load_val == {DUR_W{1'b0}}) ? DUR_W'(1) : load_val;
  assign dec_s          = tick && (cnt_r > DUR_W'(1));
  assign last           = (cnt_r == DUR_W'(1));
  assign at_gap         = (cnt_r == DUR_W'(GAP_TICKS + 1));
  assign long_note      = (load_clamped_s > DUR_W'(GAP_TICKS));

  // Live count and frozen resume count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= {DUR_W{1'b0}};
      saved_cnt_r <= {DUR_W{1'b0}};
    end else begin
      if (load) begin
        cnt_r <= load_clamped_s;
      end else if (restore) begin
        cnt_r <= saved_cnt_r;
      end else if (dec_s) begin
        cnt_r <= cnt_r - DUR_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (save) begin
        saved_cnt_r <= dec_s ? (cnt_r - DUR_W'(1)) : cnt_r;
      end else begin
        saved_cnt_r <= saved_cnt_r;
      end
    end
  end

endmodule

// File: rtl/tone_arbiter.sv
// Arbitrates the buzzer tone divider between music notes and pre-empting sound effects.
module tone_arbiter
  import tone_pkg::*;
#(
  parameter int DIV_W     = DIV_W_DEF,
  parameter int DUR_W     = DUR_W_DEF,
  parameter int GAP_TICKS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             mus_valid,
  output logic             mus_ready,
  input  logic [DIV_W-1:0] mus_div,
  input  logic [DUR_W-1:0] mus_dur,
  input  logic             sfx_valid,
  output logic             sfx_ready,
  input  logic [DIV_W-1:0] sfx_div,
  input  logic [DUR_W-1:0] sfx_dur,
  input  logic             mute,
  output logic [DIV_W-1:0] note_div,
  output logic [1:0]       src,
  output logic             busy
);

  state_t           state_r, next_state_s, phase_next_s;
  state_t           saved_phase_r;
  logic             resume_r, gap_en_r;
  logic [DIV_W-1:0] mus_div_r, sfx_div_r, saved_div_r;
  logic [DIV_W-1:0] note_div_r, next_div_s;
  logic [1:0]       src_r, next_src_s;
  logic             busy_r;

  logic             load_s, save_s, restore_s, preempt_s;
  logic             accept_mus_s, accept_sfx_s;
  logic [DUR_W-1:0] load_val_s;
  logic             last_s, at_gap_s, long_note_s, timer_tick_s;

  assign mus_ready    = (state_r == ST_IDLE) && !sfx_valid;
  assign sfx_ready    = (state_r != ST_SFX);
  assign timer_tick_s = tick && (state_r != ST_IDLE);
  assign note_div     = note_div_r;
  assign src          = src_r;
  assign busy         = busy_r;

  note_timer #(
    .DUR_W     (DUR_W),
    .GAP_TICKS (GAP_TICKS)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .tick      (timer_tick_s),
    .load      (load_s),
    .load_val  (load_val_s),
    .save      (save_s),
    .restore   (restore_s),
    .last      (last_s),
    .at_gap    (at_gap_s),
    .long_note (long_note_s)
  );

  // Next-state and handshake decode
  always_comb begin
    next_state_s = state_r;
    phase_next_s = state_r;
    load_s       = 1'b0;
    load_val_s   = mus_dur;
    save_s       = 1'b0;
    restore_s    = 1'b0;
    preempt_s    = 1'b0;
    accept_mus_s = 1'b0;
    accept_sfx_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sfx_valid) begin
          accept_sfx_s = 1'b1;
          load_s       = 1'b1;
          load_val_s   = sfx_dur;
          next_state_s = ST_SFX;
        end else if (mus_valid) begin
          accept_mus_s = 1'b1;
          load_s       = 1'b1;
          next_state_s = ST_MUSIC;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_MUSIC, ST_GAP: begin
        if ((state_r == ST_MUSIC) && tick && gap_en_r && at_gap_s) begin
          phase_next_s = ST_GAP;
        end else if (tick && last_s) begin
          phase_next_s = ST_IDLE;
        end else begin
          phase_next_s = state_r;
        end
        // An SFX landing on the expiring tick finds the note already complete.
        if (sfx_valid) begin
          accept_sfx_s = 1'b1;
          load_s       = 1'b1;
          load_val_s   = sfx_dur;
          next_state_s = ST_SFX;
          if (phase_next_s != ST_IDLE) begin
            save_s    = 1'b1;
            preempt_s = 1'b1;
          end else begin
            save_s    = 1'b0;
          end
        end else begin
          next_state_s = phase_next_s;
        end
      end
      ST_SFX: begin
        if (tick && last_s) begin
          if (resume_r) begin
            restore_s    = 1'b1;
            next_state_s = saved_phase_r;
          end else begin
            next_state_s = ST_IDLE;
          end
        end else begin
          next_state_s = ST_SFX;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Divider and source that accompany the next state
  always_comb begin
    next_div_s = {DIV_W{1'b0}};
    next_src_s = SRC_IDLE;
    case (next_state_s)
      ST_MUSIC: begin
        next_src_s = SRC_MUS;
        if (accept_mus_s) begin
          next_div_s = mus_div;
        end else if (restore_s) begin
          next_div_s = saved_div_r;
        end else begin
          next_div_s = mus_div_r;
        end
      end
      ST_GAP: begin
        next_src_s = SRC_MUS;
      end
      ST_SFX: begin
        next_src_s = SRC_SFX;
        next_div_s = accept_sfx_s ? sfx_div : sfx_div_r;
      end
      default: begin
        next_src_s = SRC_IDLE;
      end
    endcase
  end

  // State, latched requests, resume slot and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      saved_phase_r <= ST_IDLE;
      resume_r      <= 1'b0;
      gap_en_r      <= 1'b0;
      mus_div_r     <= {DIV_W{1'b0}};
      sfx_div_r     <= {DIV_W{1'b0}};
      saved_div_r   <= {DIV_W{1'b0}};
      note_div_r    <= {DIV_W{1'b0}};
      src_r         <= SRC_IDLE;
      busy_r        <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (accept_mus_s) begin
        mus_div_r <= mus_div;
        gap_en_r  <= long_note_s;
      end
      if (accept_sfx_s) begin
        sfx_div_r <= sfx_div;
      end
      if (preempt_s) begin
        resume_r      <= 1'b1;
        saved_phase_r <= phase_next_s;
        saved_div_r   <= mus_div_r;
      end else if (restore_s) begin
        resume_r <= 1'b0;
      end
      note_div_r <= mute ? {DIV_W{1'b0}} : next_div_s;
      src_r      <= next_src_s;
      busy_r     <= (next_state_s != ST_IDLE);
    end
  end

endmodule
